// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory load/store unit.
// Width codes, FSM states, response codes and load extension.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RESP    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } rsp_err_e;

  function automatic logic [WORD_W-1:0] load_ext(
    input logic [WORD_W-1:0] w,
    input logic [2:0]        f3,
    input logic [1:0]        off
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [WORD_W-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response handshake bundle of the LSU.
// master = core side, slave = LSU side.
interface dmem_lsu_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: byte-enabled word array, synchronous write,
// READ_LAT-stage registered read; contents survive reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem  [DEPTH];
  logic [WORD_W-1:0] pipe [READ_LAT];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) pipe[0] <= mem[addr];
    for (int s = 1; s < READ_LAT; s++) begin
      pipe[s] <= pipe[s-1];
    end
  end

  assign rdata = pipe[READ_LAT-1];

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding RV32 load/store unit over dmem_ram.
// Checks, lane steering, load extension and the handshake FSM.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int MEM_SIZE = 1024,
  parameter int READ_LAT = 1
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);

  localparam int          AW    = $clog2(MEM_SIZE);
  localparam logic [32:0] LIMIT = 33'(MEM_SIZE) << 2;

  state_e            state, state_nxt;
  rsp_err_e          chk_err;
  logic              accept;
  logic              illegal;
  logic              misalign;
  logic              oor;
  logic [1:0]        f3_lo;
  logic [1:0]        off;
  logic [1:0]        cnt;
  logic              rd_done;
  logic [2:0]        op_f3;
  logic [1:0]        op_off;
  logic [3:0]        wmask;
  logic [WORD_W-1:0] wlane;
  logic [WORD_W-1:0] ram_rdata;
  logic              ram_we;
  logic              ram_re;
  logic [WORD_W-1:0] rdata_q;
  logic [1:0]        err_q;

  assign f3_lo = bus.req_funct3[1:0];
  assign off   = bus.req_addr[1:0];

  assign bus.req_ready = rst && (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign accept  = bus.req_valid && bus.req_ready;
  assign rd_done = (state == S_RD_WAIT) &&
                   (cnt == 2'(READ_LAT - 1));

  always_comb begin
    illegal = 1'b0;
    case (bus.req_funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = bus.req_we;
      default:          illegal = 1'b1;
    endcase
  end

  assign misalign = (f3_lo == 2'b01 && off[0]) ||
                    (f3_lo == 2'b10 && off != 2'b00);
  assign oor      = {1'b0, bus.req_addr} >= LIMIT;

  always_comb begin
    chk_err = ERR_OK;
    if (illegal)       chk_err = ERR_ILLEGAL;
    else if (misalign) chk_err = ERR_MISALIGN;
    else if (oor)      chk_err = ERR_RANGE;
  end

  // Narrow stores replicate across lanes; the mask picks the target.
  always_comb begin
    wmask = 4'b1111;
    wlane = bus.req_wdata;
    unique case (1'b1)
      f3_lo == 2'b00: begin
        wmask = 4'b0001 << off;
        wlane = {4{bus.req_wdata[7:0]}};
      end
      f3_lo == 2'b01: begin
        wmask = 4'b0011 << off;
        wlane = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ram_we = accept && bus.req_we && (chk_err == ERR_OK);
  assign ram_re = accept && !bus.req_we && (chk_err == ERR_OK);

  dmem_ram #(
    .DEPTH    (MEM_SIZE),
    .READ_LAT (READ_LAT)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (wmask),
    .addr  (bus.req_addr[AW+1:2]),
    .wdata (wlane),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (chk_err != ERR_OK || bus.req_we) state_nxt = S_RESP;
          else                                 state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: if (rd_done)       state_nxt = S_RESP;
      S_RESP:    if (bus.rsp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      op_f3   <= '0;
      op_off  <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else if (accept) begin
      cnt     <= '0;
      op_f3   <= bus.req_funct3;
      op_off  <= off;
      rdata_q <= '0;
      err_q   <= chk_err;
    end else if (state == S_RD_WAIT) begin
      if (rd_done) rdata_q <= load_ext(ram_rdata, op_f3, op_off);
      else         cnt     <= cnt + 2'd1;
    end
  end

endmodule
